// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB requester and the config-bus register map.
package apb_master_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] CNTRL = 32'h0000_0000;
    localparam logic [31:0] REG1  = 32'h0000_0004;
    localparam logic [31:0] REG2  = 32'h0000_0008;
    localparam logic [31:0] REG3  = 32'h0000_000C;
    localparam logic [31:0] REG4  = 32'h0000_0010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RDWAIT = 2'd3
    } state_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Purpose: valid/ready command to APB3 SETUP/ACCESS transfer bridge, one transfer in flight.
// Latency: response 2 cycles after accept for writes, 3 for reads with RD_SAMPLE_DLY=1, plus wait states.
// Backpressure: cmd_ready only in IDLE; pready stretches ACCESS until done or timeout; rsp has none.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int RD_SAMPLE_DLY = 1,
    parameter int TIMEOUT_CYC   = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   to_cnt;
    logic               err_q;
    logic               accept;
    logic               timeout_hit;
    logic               access_done;
    logic               direct_rsp;

    assign accept      = (state == IDLE) && cmd_valid;
    assign timeout_hit = (TIMEOUT_CYC != 0) && !pready &&
                         (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign access_done = (state == ACCESS) && pready;
    // Reads with registered slave data take the detour through RDWAIT.
    assign direct_rsp  = pwrite || (RD_SAMPLE_DLY == 0);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (pready)           state_nxt = direct_rsp ? IDLE : RDWAIT;
                else if (timeout_hit) state_nxt = IDLE;
            end
            RDWAIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            SETUP:   psel      = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            to_cnt    <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pwrite <= cmd_write;
                to_cnt <= '0;
            end
            if ((state == ACCESS) && !pready) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            if (access_done) begin
                err_q <= pslverr;
                if (direct_rsp) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= pslverr;
                    rsp_rdata <= pwrite ? '0 : prdata;
                end
            end else if ((state == ACCESS) && timeout_hit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
            // prdata from a registered slave is valid during RDWAIT.
            if (state == RDWAIT) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_q;
                rsp_rdata <= prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench: drives the bridge against a small registered-read register-file slave.
module tb_apb_master_bridge;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int checks = 0;
    int errors = 0;

    logic [3:0]  s_cntrl = '0;
    logic [31:0] s_reg1 = '0, s_reg2 = '0, s_reg3 = '0, s_reg4 = '0;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .RD_SAMPLE_DLY(1), .TIMEOUT_CYC(16)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave registers read data on the ACCESS completion edge.
    always @(posedge pclk) begin
        if (psel && penable && pready) begin
            if (pwrite) begin
                case (paddr)
                    32'h0:  s_cntrl <= pwdata[3:0];
                    32'h4:  s_reg1  <= pwdata;
                    32'h8:  s_reg2  <= pwdata;
                    32'hC:  s_reg3  <= pwdata;
                    32'h10: s_reg4  <= pwdata;
                    default: ;
                endcase
            end else begin
                case (paddr)
                    32'h0:  prdata <= {28'h0, s_cntrl};
                    32'h4:  prdata <= s_reg1;
                    32'h8:  prdata <= s_reg2;
                    32'hC:  prdata <= s_reg3;
                    32'h10: prdata <= s_reg4;
                    default: prdata <= 32'h0;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the bridge idle.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int nsel, output int nen);
        bit got;
        got = 0; lat = 0; nsel = 0; nen = 0; rd = 'x; er = 1'bx;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            if (psel) nsel++;
            if (penable) nen++;
            @(posedge pclk); #1;
            if (rsp_valid) begin
                got = 1; lat = i; rd = rsp_rdata; er = rsp_err;
            end
        end
        if (!got) chk("rsp_timeout", 32'h0, 32'h1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, nsel, nen;
    logic [31:0] a0, d0;
    bit          stable, spurious;

    initial begin
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; pready = 1'b1; pslverr = 1'b0;
        #2;
        chk("rst_psel", {31'h0, psel}, 32'h0);
        chk("rst_penable", {31'h0, penable}, 32'h0);
        chk("rst_pwrite", {31'h0, pwrite}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Write REG1, no wait states.
        run_cmd(1'b1, 32'h4, 32'hDEADBEEF, rd, er, lat, nsel, nen);
        chk("wr1_lat", 32'(lat), 32'd2);
        chk("wr1_psel_cycles", 32'(nsel), 32'd2);
        chk("wr1_penable_cycles", 32'(nen), 32'd1);
        chk("wr1_err", {31'h0, er}, 32'h0);
        chk("wr1_rdata", rd, 32'h0);
        chk("wr1_cmd_ready_in_rsp", {31'h0, cmd_ready}, 32'h1);
        chk("wr1_slave_reg1", s_reg1, 32'hDEADBEEF);

        // Read back, accepted in the response cycle.
        run_cmd(1'b0, 32'h4, 32'h0, rd, er, lat, nsel, nen);
        chk("rd1_lat", 32'(lat), 32'd3);
        chk("rd1_rdata", rd, 32'hDEADBEEF);
        chk("rd1_err", {31'h0, er}, 32'h0);
        chk("rd1_psel_cycles", 32'(nsel), 32'd2);

        run_cmd(1'b1, 32'h0, 32'hFFFFFFFF, rd, er, lat, nsel, nen);
        chk("wr_cntrl_lat", 32'(lat), 32'd2);
        run_cmd(1'b0, 32'h0, 32'h0, rd, er, lat, nsel, nen);
        chk("rd_cntrl_rdata", rd, 32'h0000000F);

        run_cmd(1'b0, 32'h20, 32'h0, rd, er, lat, nsel, nen);
        chk("rd_unmapped_rdata", rd, 32'h0);
        chk("rd_unmapped_err", {31'h0, er}, 32'h0);

        // Three wait states, then completion with a slave error.
        pready = 1'b0; pslverr = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h12345678;
        @(posedge pclk); #1;
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'h0;
        a0 = paddr; d0 = pwdata;
        chk("ws_setup_paddr", a0, 32'h8);
        chk("ws_setup_pwdata", d0, 32'h12345678);
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            if (paddr !== a0 || pwdata !== d0 || pwrite !== 1'b1 || !psel || !penable) stable = 1'b0;
            if (rsp_valid) stable = 1'b0;
        end
        chk("ws_bus_stable", {31'h0, stable}, 32'h1);
        pready = 1'b1;
        @(posedge pclk); #1;
        chk("ws_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("ws_rsp_err", {31'h0, rsp_err}, 32'h1);
        pslverr = 1'b0;
        @(posedge pclk); #1;
        chk("ws_err_held", {31'h0, rsp_err}, 32'h1);
        chk("ws_rsp_single_pulse", {31'h0, rsp_valid}, 32'h0);

        // Stuck slave: abort after 16 stalled ACCESS cycles.
        pready = 1'b0;
        run_cmd(1'b0, 32'h10, 32'h0, rd, er, lat, nsel, nen);
        chk("to_lat", 32'(lat), 32'd17);
        chk("to_penable_cycles", 32'(nen), 32'd16);
        chk("to_err", {31'h0, er}, 32'h1);
        chk("to_rdata", rd, 32'h0);
        chk("to_psel_after", {31'h0, psel}, 32'h0);

        // Reset during ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'hA5A5A5A5;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("rstmid_in_access", {30'h0, psel, penable}, 32'h3);
        presetn = 1'b0;
        #1;
        chk("rstmid_bus_dropped", {30'h0, psel, penable}, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            if (rsp_valid) spurious = 1'b1;
        end
        chk("rstmid_no_rsp", {31'h0, spurious}, 32'h0);
        pready = 1'b1;
        run_cmd(1'b0, 32'h4, 32'h0, rd, er, lat, nsel, nen);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);
        chk("post_rst_err", {31'h0, er}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks", checks);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (master) that turns a simple valid/ready command interface into APB3 SETUP/ACCESS transfers, one transfer at a time.
- Drives the register-file slaves on the config bus: the control register and data registers at 0x0/0x4/0x8/0xC/0x10.
- Returns read data and an error flag on a single-cycle response pulse.
- Handles wait states (pready), slave errors (pslverr), stalled slaves (timeout) and slaves with registered read data (sample delay).

Parameters:
- ADDR_W, 32, paddr/cmd_addr width
- DATA_W, 32, pwdata/prdata width
- RD_SAMPLE_DLY, 1, cycles after read completion before prdata is captured (0 or 1; 1 for slaves that register read data on the ACCESS edge)
- TIMEOUT_CYC, 16, max consecutive ACCESS cycles with pready=0 before abort; 0 disables the timeout

Ports:
- pclk  in  1  clock, rising edge
- presetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  DATA_W  captured read data (0 for writes and timeouts)
- rsp_err  out  1  pslverr or timeout
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pready  in  1  slave ready; tie high for slaves without wait states
- pslverr  in  1  slave error; tie low if unused
- prdata  in  DATA_W  slave read data

Behaviour:
- Reset (async, immediate): state=IDLE; psel, penable, pwrite=0; paddr, pwdata=0; rsp_valid, rsp_err=0; rsp_rdata=0; counters cleared. cmd_ready is 1 after reset.
- Reset mid-transfer: bus is dropped at once and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RDWAIT.
- IDLE: cmd_ready=1, psel=0, penable=0. On accept, latch addr/wdata/write into paddr/pwdata/pwrite and go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, then ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwdata/pwrite are stable throughout SETUP and ACCESS.
- ACCESS completes on an edge with pready=1:
  - Write, or read with RD_SAMPLE_DLY=0: capture prdata (reads only) and pslverr, go to IDLE, rsp_valid=1 in the next cycle.
  - Read with RD_SAMPLE_DLY=1: capture pslverr, go to RDWAIT.
- RDWAIT (1 cycle): psel=0, penable=0, paddr held. At the end of the cycle capture prdata, go to IDLE, rsp_valid=1 in the next cycle.
- Timeout: a counter increments on each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC, abort at that edge: go to IDLE, rsp_err=1, rsp_rdata=0, rsp_valid pulses. No RDWAIT on abort.
  - The counter clears on entry to SETUP.
- pslverr=1 at completion: rsp_err=1; read data is still captured.
- rsp_valid may be high in the same cycle as IDLE/cmd_ready=1, so a new command can be accepted in the response cycle.
- Back-to-back throughput with pready tied high: 3 cycles per write; 4 per read when RD_SAMPLE_DLY=1.
- rsp_rdata/rsp_err hold their values until the next response.
- psel deasserts between transfers; the master never chains ACCESS directly into the next SETUP.
- cmd_* are ignored outside IDLE.

Decomposition:
- apb_master_pkg: state enum (IDLE, SETUP, ACCESS, RDWAIT), default ADDR_W/DATA_W constants, and the address localparams for the register map: CNTRL=0x0, REG1=0x4, REG2=0x8, REG3=0xC, REG4=0x10.
- Single module; the timeout counter is inline. No sub-module.

Test Plan:
- Reset then write 0x4 = 0xDEADBEEF with pready=1 -> psel high 2 cycles, penable high 1 cycle; rsp_valid pulses 2 cycles after accept with rsp_err=0; slave reg1 = 0xDEADBEEF.
- Read 0x4 after that write, RD_SAMPLE_DLY=1 against the registered-read slave -> rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after accept.
- Write 0x0 = 0xFFFFFFFF, then read 0x0 -> rsp_rdata=0x0000000F.
- Read unmapped address 0x20 -> rsp_rdata=0, rsp_err=0.
- pready held low 3 ACCESS cycles then high, pslverr=1 -> paddr/pwdata stable throughout; rsp_err=1.
- pready stuck low with TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel=0 next cycle.
- presetn asserted during ACCESS -> psel/penable drop immediately, no rsp_valid; first command after release completes normally.
